// File: rtl/imem_program_loader.sv
// imem_program_loader
// Encodes decoded-style commands (kind/aluop/register fields/immediate) into
// 32-bit MIPS instruction words and writes them sequentially into instruction
// memory, holding the CPU in stall for the whole load session.
// Optional feature: define LOADER_VERIFY_EN to read back and compare every
// written word before moving on to the next address.
module imem_program_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [3:0]        aluop,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  // Controller encodings (shared with the instruction controller)
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3
`ifdef LOADER_VERIFY_EN
    ,
    S_VFY_RD  = 3'd4,
    S_VFY_CMP = 3'd5
`endif
  } state_t;

  // Returns {legal, word}; legal=0 means the command must not be written.
  function automatic logic [32:0] encode_cmd(
    input logic [2:0]  k,
    input logic [3:0]  op,
    input logic [4:0]  rs_v,
    input logic [4:0]  rt_v,
    input logic [4:0]  rd_v,
    input logic [4:0]  sh_v,
    input logic [15:0] imm_v
  );
    logic [32:0] res;
    logic [5:0]  fn;
    logic [5:0]  iop;
    logic        is_shift;
    logic        ok;
    res      = 33'd0;
    fn       = 6'd0;
    iop      = 6'd0;
    is_shift = 1'b0;
    ok       = 1'b1;
    case (k)
      3'd0: begin
        case (op)
          ALU_ADD:  fn = FN_ADD;
          ALU_ADDU: fn = FN_ADDU;
          ALU_SUB:  fn = FN_SUB;
          ALU_SUBU: fn = FN_SUBU;
          ALU_AND:  fn = FN_AND;
          ALU_OR:   fn = FN_OR;
          ALU_NOR:  fn = FN_NOR;
          ALU_SLT:  fn = FN_SLT;
          ALU_SLL:  begin fn = FN_SLL; is_shift = 1'b1; end
          ALU_SRL:  begin fn = FN_SRL; is_shift = 1'b1; end
          ALU_SRA:  begin fn = FN_SRA; is_shift = 1'b1; end
          default:  ok = 1'b0;
        endcase
        // Shifts take their operand from rt only; other ALU ops have no shamt
        if (is_shift) begin
          res = {ok, OP_R_TYPE, 5'd0, rt_v, rd_v, sh_v, fn};
        end else begin
          res = {ok, OP_R_TYPE, rs_v, rt_v, rd_v, 5'd0, fn};
        end
      end
      3'd1: begin
        case (op)
          ALU_ADD:  iop = OP_ADDI;
          ALU_ADDU: iop = OP_ADDIU;
          ALU_AND:  iop = OP_ANDI;
          ALU_OR:   iop = OP_ORI;
          ALU_SLT:  iop = OP_SLTI;
          default:  ok  = 1'b0;
        endcase
        res = {ok, iop, rs_v, rt_v, imm_v};
      end
      3'd2:    res = {1'b1, OP_LW, rs_v, rt_v, imm_v};
      3'd3:    res = {1'b1, OP_SB, rs_v, rt_v, imm_v};
      3'd4:    res = {1'b1, OP_SH, rs_v, rt_v, imm_v};
      3'd5:    res = {1'b1, OP_R_TYPE, rs_v, 15'd0, FN_JR};
      3'd6:    res = {1'b1, OP_LUI, 5'd0, rt_v, imm_v};
      default: res = 33'd0;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              in_ready_q, imem_we_q, cpu_hold_q, done_q;
  logic [32:0]       enc_s;
  state_t            adv_state_s;
  logic              adv_err_s;

  assign enc_s = encode_cmd(kind, aluop, rs, rt, rd, shamt, imm);

`ifndef LOADER_VERIFY_EN
  // Read-back data only matters when verification is built in
  logic unused_rdata_s;
  assign unused_rdata_s = ^imem_rdata;
`endif

  // Next-state and datapath updates for the load session
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    // Exit after a committed word: stop on last or when the address space is used up
    adv_state_s = (last_q || (&addr_q)) ? S_DONE : S_ACCEPT;
    adv_err_s   = err_q | (~last_q & (&addr_q));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = BASE;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_ACCEPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          if (enc_s[32]) begin
            wdata_d = enc_s[31:0];
            last_d  = last;
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = last ? S_DONE : S_ACCEPT;
          end
        end else begin
          state_d = S_ACCEPT;
        end
      end
`ifdef LOADER_VERIFY_EN
      S_WRITE:  state_d = S_VFY_RD;
      S_VFY_RD: state_d = S_VFY_CMP;
      S_VFY_CMP: begin
        if (imem_rdata != wdata_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q + CNT_ONE;
          err_d   = adv_err_s;
          state_d = adv_state_s;
        end
      end
`else
      S_WRITE: begin
        addr_d  = addr_q + ADDR_ONE;
        count_d = count_q + CNT_ONE;
        err_d   = adv_err_s;
        state_d = adv_state_s;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE;
      count_q    <= '0;
      err_q      <= 1'b0;
      wdata_q    <= 32'd0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      in_ready_q <= (state_d == S_ACCEPT);
      imem_we_q  <= (state_d == S_WRITE);
      cpu_hold_q <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed sessions from the
// test plan plus randomized sessions against a table-driven reference model.
module tb_imem_program_loader;

  localparam int AW   = 3;
  localparam int BASE = 1;
  localparam int NW   = 1 << AW;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
  } cmd_t;

  // Function codes / I-type opcodes indexed by aluop; -1 means no such form
  localparam int RFN [16] = '{32, 33, 34, 35, 36, 37, 39, 0, 2, 3, 42, -1, -1, -1, -1, -1};
  localparam int IOP [16] = '{8, 9, -1, -1, 12, 13, -1, -1, -1, -1, 10, -1, -1, -1, -1, -1};

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, last;
  logic [2:0] kind;
  logic [3:0] aluop;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;
  logic imem_we, cpu_hold, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata, imem_rdata;
  logic [AW:0] count;

  logic [31:0] mem [NW];
  logic corrupt = 1'b0;
  int we_total = 0;
  int n_vec = 0;
  int n_err = 0;
  cmd_t q[$];

  always #5 clk = ~clk;

  imem_program_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .aluop(aluop), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .last(last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
  );

  // Instruction memory with one-cycle read latency
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      we_total <= we_total + 1;
    end
    imem_rdata <= mem[imem_addr] ^ {31'd0, corrupt};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input int k, input int op, input int s, input int t,
                              input int d, input int sa, input int im);
    cmd_t c;
    c.kind = 3'(k); c.aluop = 4'(op); c.rs = 5'(s); c.rt = 5'(t);
    c.rd = 5'(d); c.sh = 5'(sa); c.imm = 16'(im);
    return c;
  endfunction

  // Reference encoder: {legal, word} assembled from field positions
  function automatic logic [32:0] ref_encode(input cmd_t c);
    int op, f;
    logic [31:0] w;
    bit shift;
    op = 0; f = 0; w = 32'd0;
    shift = (c.aluop >= 4'd7) && (c.aluop <= 4'd9);
    if (c.kind == 3'd0) begin
      if (RFN[c.aluop] < 0) return 33'd0;
      w = (32'(shift ? 5'd0 : c.rs) << 21) | (32'(c.rt) << 16) | (32'(c.rd) << 11)
        | (32'(shift ? c.sh : 5'd0) << 6) | 32'(RFN[c.aluop]);
    end else if (c.kind == 3'd1) begin
      if (IOP[c.aluop] < 0) return 33'd0;
      w = (32'(IOP[c.aluop]) << 26) | (32'(c.rs) << 21) | (32'(c.rt) << 16) | 32'(c.imm);
    end else if (c.kind >= 3'd2 && c.kind <= 3'd4) begin
      op = (c.kind == 3'd2) ? 35 : (c.kind == 3'd3) ? 40 : 41;
      w = (32'(op) << 26) | (32'(c.rs) << 21) | (32'(c.rt) << 16) | 32'(c.imm);
    end else if (c.kind == 3'd5) begin
      w = (32'(c.rs) << 21) | 32'd8;
    end else if (c.kind == 3'd6) begin
      w = (32'd15 << 26) | (32'(c.rt) << 16) | 32'(c.imm);
    end else begin
      return 33'd0;
    end
    return {1'b1, w};
  endfunction

  task automatic drive(input cmd_t c, input bit lst);
    kind = c.kind; aluop = c.aluop; rs = c.rs; rt = c.rt;
    rd = c.rd; shamt = c.sh; imm = c.imm; last = lst;
  endtask

  task automatic run_session(input cmd_t cmds[$], input bit exp_verify_fail);
    int m_addr, m_cnt, w0, wn, i;
    bit m_err, fin;
    logic [32:0] e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_hold", cpu_hold, 1);
    check("start_err_clr", err, 0);
    check("start_count", count, 0);
    check("start_addr", imem_addr, BASE);
    m_addr = BASE; m_cnt = 0; m_err = 0; fin = 0; w0 = we_total; i = 0;
    while (!fin && i < cmds.size()) begin
      drive(cmds[i], i == cmds.size() - 1);
      in_valid = 1'b1;
      wn = 0;
      while (!in_ready && wn < 20) begin @(negedge clk); wn++; end
      check("ready_timeout", wn < 20, 1);
      if (wn >= 20) begin in_valid = 1'b0; fin = 1; break; end
      @(negedge clk);
      in_valid = 1'b0;
      e = ref_encode(cmds[i]);
      if (e[32]) begin
        check("we", imem_we, 1);
        check("addr", imem_addr, m_addr);
        check("wdata", imem_wdata, e[31:0]);
        if (exp_verify_fail) begin
          m_err = 1; fin = 1;
        end else begin
          m_cnt++;
          if (last) fin = 1;
          else if (m_addr == NW - 1) begin m_err = 1; fin = 1; end
          m_addr = (m_addr + 1) % NW;
        end
      end else begin
        check("we_illegal", imem_we, 0);
        m_err = 1;
        if (last) fin = 1;
      end
      i++;
    end
    // Offer the next command if the session ended early; it must not be taken
    if (i < cmds.size()) begin drive(cmds[i], 1'b1); in_valid = 1'b1; end
    wn = 0;
    while (!done && wn < 20) begin @(negedge clk); wn++; end
    check("done_seen", done, 1);
    check("done_hold", cpu_hold, 1);
    check("done_count", count, m_cnt);
    check("done_err", err, m_err);
    @(negedge clk);
    in_valid = 1'b0;
    check("done_pulse", done, 0);
    check("hold_drop", cpu_hold, 0);
    check("idle_ready", in_ready, 0);
    check("write_total", we_total - w0, m_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 0);
    rst = 1'b0;

    // ADD r3, r1, r2
    q = {}; q.push_back(mk(0, 0, 1, 2, 3, 0, 0));
    run_session(q, 1'b0);
    check("mem_add", mem[BASE], 32'h00221820);

    // ORI then LW
    q = {}; q.push_back(mk(1, 5, 0, 8, 0, 0, 16'h00FF)); q.push_back(mk(2, 0, 29, 4, 0, 0, 16'h0010));
    run_session(q, 1'b0);
    check("mem_ori", mem[BASE], 32'h340800FF);
    check("mem_lw", mem[BASE + 1], 32'h8FA40010);

    // SLL forces rs to zero
    q = {}; q.push_back(mk(0, 7, 7, 2, 2, 4, 0));
    run_session(q, 1'b0);
    check("mem_sll", mem[BASE], 32'h00021100);

    // Illegal I-ALU SUB, then a legal command still lands at the base address
    q = {}; q.push_back(mk(1, 2, 3, 4, 0, 0, 16'h1234)); q.push_back(mk(5, 0, 31, 0, 0, 0, 0));
    run_session(q, 1'b0);
    check("mem_jr_after_illegal", mem[BASE], 32'h03E00008);

    // Overflow: more legal commands than address space above BASE
    q = {};
    for (int k = 0; k < NW; k++) q.push_back(mk(1, 0, 1, 2, 0, 0, k));
    run_session(q, 1'b0);

    // Asynchronous reset in the middle of the second write
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int w0, wn;
      w0 = we_total;
      for (int k = 0; k < 2; k++) begin
        drive(mk(6, 0, 0, 9, 0, 0, 16'hABCD), 1'b0);
        in_valid = 1'b1;
        wn = 0;
        while (!in_ready && wn < 20) begin @(negedge clk); wn++; end
        check("rst_test_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
      end
      check("rst_test_we_before", imem_we, 1);
      check("rst_test_count_before", count, 1);
      #1 rst = 1'b1;
      #1;
      check("async_we", imem_we, 0);
      check("async_hold", cpu_hold, 0);
      check("async_count", count, 0);
      check("async_addr", imem_addr, BASE);
      @(negedge clk); rst = 1'b0;
      check("rst_test_writes", we_total - w0, 1);
    end

`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    q = {}; q.push_back(mk(0, 1, 4, 5, 6, 0, 0));
    run_session(q, 1'b1);
    corrupt = 1'b0;
`endif

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int n;
      n = int'($urandom_range(1, 10));
      q = {};
      for (int k = 0; k < n; k++)
        q.push_back(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 65535))));
      run_session(q, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Inverse of the instruction controller. The controller decodes opcode/func into control lines; this block takes a decoded-style command (instruction kind, aluop, register fields, immediate) and encodes it into a 32-bit MIPS instruction word.
- Encoded words are written sequentially into instruction memory.
- The CPU is held in stall while a load session is active.
- Used for boot-time program load and for directed CPU tests.
- All OP_/FN_/ALU_ encodings come from controller_constants.vh.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written in each session

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin load session (sampled in IDLE only)
in_valid  in  1  command valid
in_ready  out  1  block accepts command this cycle
kind  in  3  0=R-ALU 1=I-ALU 2=LW 3=SB 4=SH 5=JR 6=LUI 7=illegal
aluop  in  4  ALU_* code (R-ALU, I-ALU only)
rs  in  5  source/base register
rt  in  5  second source / I-type destination
rd  in  5  R-type destination
shamt  in  5  shift amount
imm  in  16  immediate/offset
last  in  1  final command of session
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  IMEM word address
imem_wdata  out  32  encoded instruction
imem_rdata  in  32  IMEM read data, 1-cycle latency (used only by the optional feature)
cpu_hold  out  1  stall CPU fetch
done  out  1  one-cycle pulse at session end
err  out  1  sticky error, cleared by start
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state=IDLE; all outputs 0; imem_addr=BASE_ADDR. Reset mid-session aborts immediately; no partial write completes.
- States:
  - IDLE: cpu_hold=0, in_ready=0. On start: imem_addr<=BASE_ADDR, count<=0, err<=0, go to ACCEPT.
  - ACCEPT: cpu_hold=1, in_ready=1.
    - On in_valid with a legal command: imem_wdata<=encoded word, latch last, go to WRITE.
    - On in_valid with an illegal command: err<=1, nothing written, count unchanged. If last, go to DONE; else stay in ACCEPT.
  - WRITE: imem_we=1 for exactly one cycle. The next cycle has imem_addr+1 and count+1. If last, go to DONE. Else, if imem_addr was all-ones, set err (overflow) and go to DONE. Else go to ACCEPT.
  - DONE: cpu_hold=1, done=1 for one cycle, then IDLE.
- Latency and throughput: accept in cycle N gives imem_we in cycle N+1. Throughput is 1 word per 2 cycles (in_ready low in WRITE).
- start outside IDLE is ignored.
- Encoding:
  - R-ALU: {OP_R_TYPE,rs,rt,rd,shamt,FN}. aluop maps ADD,ADDU,SUB,SUBU,AND,OR,NOR,SLL,SRL,SRA,SLT to the matching FN_*.
  - R-ALU shifts force rs=0; non-shifts force shamt=0. Any other aluop is illegal.
  - I-ALU: {OP,rs,rt,imm}. ADD→OP_ADDI, ADDU→OP_ADDIU, AND→OP_ANDI, OR→OP_ORI, SLT→OP_SLTI. Others are illegal.
  - LW, SB, SH: {OP_LW/OP_SB/OP_SH,rs,rt,imm}. aluop ignored.
  - JR: {OP_R_TYPE,rs,15'b0,FN_JR}.
  - LUI: {OP_LUI,5'b0,rt,imm}.
  - kind 7: illegal.
- imem_addr and imem_wdata are held stable outside WRITE.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined:
  - WRITE is followed by VERIFY (2 cycles, address held): cycle 1 issues the read, cycle 2 compares imem_rdata with imem_wdata.
  - Mismatch: err<=1, go to DONE.
  - Match: continue as WRITE's normal exit (addr/count increment after VERIFY).
  - Throughput becomes 1 word per 4 cycles.
- Undefined: no VERIFY state; imem_rdata is ignored.

Test Plan:
- Start; R-ALU ADD rs=1 rt=2 rd=3 last=1 → one imem_we at addr 0, wdata=0x00221820, count=1, done pulse, cpu_hold falls after done.
- I-ALU OR rs=0 rt=8 imm=0x00FF, then LW rs=29 rt=4 imm=0x0010 last=1 → 0x340800FF @0, 0x8FA40010 @1, count=2, err=0.
- R-ALU SLL rs=7 rt=2 rd=2 shamt=4 → rs forced to 0, wdata=0x00021100.
- I-ALU with aluop=SUB → no imem_we, err=1, count=0. A following legal command still writes at addr 0.
- ADDR_W=2, five commands with last only on the fifth → writes at 0–3, err=1 after the fourth write, done, fifth never accepted.
- Assert rst during WRITE → imem_we, cpu_hold, count go to 0 asynchronously. With LOADER_VERIFY_EN, force imem_rdata≠wdata → err=1, done.
